// File: rtl/voice_allocator.sv
// Purpose: three-slot polyphonic voice allocator with per-slot beat countdown and voice stealing.
// Latency: new_note, expiry, note_done and overflow all appear one clk after the causing edge.
// Backpressure: none; every new_note with nonzero duration is taken, stealing a voice when all are busy.
module voice_allocator #(
  parameter int NUM_VOICES = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    play,
  input  logic                    beat,
  input  logic                    new_note,
  input  logic [5:0]              note,
  input  logic [5:0]              duration,
  input  logic [2:0]              metadata,
  output logic [NUM_VOICES-1:0]   voice_active,
  output logic [6*NUM_VOICES-1:0] voice_notes,
  output logic [3*NUM_VOICES-1:0] voice_meta,
  output logic                    note_done,
  output logic                    overflow
);

  localparam int IW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

  // Per-slot registered state; packed so slot i lands at the documented bit range.
  logic [NUM_VOICES-1:0]      active_q, active_d;
  logic [NUM_VOICES-1:0][5:0] note_q,   note_d;
  logic [NUM_VOICES-1:0][2:0] meta_q,   meta_d;
  logic [NUM_VOICES-1:0][5:0] rem_q,    rem_d;
  logic                       note_done_q, note_done_d;
  logic                       overflow_q,  overflow_d;

  // Slot selection results.
  logic          idle_found;
  logic [IW-1:0] idle_idx;
  logic [IW-1:0] steal_idx;
  logic [5:0]    steal_rem;
  logic [IW-1:0] tgt_idx;
  logic          tick;
  logic          load;

  assign tick    = beat & play;
  assign load    = new_note & (duration != 6'd0);
  assign tgt_idx = idle_found ? idle_idx : steal_idx;

  // Pick the lowest idle slot, and the busy slot closest to expiry as steal victim.
  always_comb begin
    idle_found = 1'b0;
    idle_idx   = '0;
    // Scan downwards so the last hit is the lowest index.
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (!active_q[i]) begin
        idle_found = 1'b1;
        idle_idx   = IW'(i);
      end
    end
    steal_idx = '0;
    steal_rem = rem_q[0];
    // Strict compare keeps the lowest index on a tie.
    for (int i = 1; i < NUM_VOICES; i++) begin
      if (rem_q[i] < steal_rem) begin
        steal_idx = IW'(i);
        steal_rem = rem_q[i];
      end
    end
  end

  // Countdown every sounding slot, then let a load override its target slot.
  always_comb begin
    active_d = active_q;
    note_d   = note_q;
    meta_d   = meta_q;
    rem_d    = rem_q;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (tick && active_q[i]) begin
        if (rem_q[i] != 6'd0) begin
          rem_d[i] = rem_q[i] - 6'd1;
        end
        if (rem_q[i] <= 6'd1) begin
          active_d[i] = 1'b0;
        end
      end
      // The load wins over the countdown, so a fresh note is not decremented this cycle.
      if (load && (tgt_idx == IW'(i))) begin
        active_d[i] = 1'b1;
        note_d[i]   = note;
        meta_d[i]   = metadata;
        rem_d[i]    = duration;
      end
    end
  end

  // Event pulses: a steal of a voice that was not about to expire, and the set going silent.
  always_comb begin
    overflow_d  = load && !idle_found && !((steal_rem == 6'd1) && tick);
    note_done_d = (|active_q) && !(|active_d);
  end

  // State register with synchronous active-low reset; reset produces no pulses.
  always_ff @(posedge clk) begin
    if (!reset) begin
      active_q    <= '0;
      note_q      <= '0;
      meta_q      <= '0;
      rem_q       <= '0;
      note_done_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      active_q    <= active_d;
      note_q      <= note_d;
      meta_q      <= meta_d;
      rem_q       <= rem_d;
      note_done_q <= note_done_d;
      overflow_q  <= overflow_d;
    end
  end

  assign voice_active = active_q;
  assign voice_notes  = note_q;
  assign voice_meta   = meta_q;
  assign note_done    = note_done_q;
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_voice_allocator.sv
// Purpose: directed self-checking bench for voice_allocator with hand-computed expectations.
// Latency: outputs sampled 1 time unit after each rising edge, i.e. the result of that edge.
// Backpressure: none; stimulus is a fixed sequence of cycles, no open-ended waits.
module tb_voice_allocator;

  logic        clk;
  logic        reset;
  logic        play;
  logic        beat;
  logic        new_note;
  logic [5:0]  note;
  logic [5:0]  duration;
  logic [2:0]  metadata;
  logic [2:0]  voice_active;
  logic [17:0] voice_notes;
  logic [8:0]  voice_meta;
  logic        note_done;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  voice_allocator #(.NUM_VOICES(3)) dut (
    .clk          (clk),
    .reset        (reset),
    .play         (play),
    .beat         (beat),
    .new_note     (new_note),
    .note         (note),
    .duration     (duration),
    .metadata     (metadata),
    .voice_active (voice_active),
    .voice_notes  (voice_notes),
    .voice_meta   (voice_meta),
    .note_done    (note_done),
    .overflow     (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h want=0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic nn(input logic [5:0] n, input logic [5:0] d, input logic [2:0] m);
    new_note = 1'b1;
    note     = n;
    duration = d;
    metadata = m;
    cyc();
    new_note = 1'b0;
  endtask

  task automatic beats(input int n);
    for (int i = 0; i < n; i++) begin
      beat = 1'b1;
      cyc();
      beat = 1'b0;
    end
  endtask

  initial begin
    reset = 1'b0; play = 1'b1; beat = 1'b0; new_note = 1'b0;
    note = '0; duration = '0; metadata = '0;
    cyc(); cyc();
    reset = 1'b1;
    chk("rst_active", voice_active, 3'b000);
    chk("rst_notes",  voice_notes,  18'd0);
    chk("rst_meta",   voice_meta,   9'd0);
    chk("rst_done",   note_done,    1'b0);
    chk("rst_ovf",    overflow,     1'b0);

    // Single note 20 for 3 beats.
    nn(6'd20, 6'd3, 3'd5);
    chk("single_active", voice_active, 3'b001);
    chk("single_note",   voice_notes[5:0], 6'd20);
    chk("single_meta",   voice_meta[2:0], 3'd5);
    beats(2);
    chk("single_b2_active", voice_active, 3'b001);
    chk("single_b2_done",   note_done, 1'b0);
    beats(1);
    chk("single_b3_active", voice_active, 3'b000);
    chk("single_b3_done",   note_done, 1'b1);
    chk("single_note_hold", voice_notes[5:0], 6'd20);
    cyc();
    chk("single_done_1cyc", note_done, 1'b0);

    // Chord fill 10/d4, 12/d2, 14/d6 back to back.
    nn(6'd10, 6'd4, 3'd1);
    nn(6'd12, 6'd2, 3'd2);
    nn(6'd14, 6'd6, 3'd3);
    chk("chord_active", voice_active, 3'b111);
    chk("chord_notes",  voice_notes, {6'd14, 6'd12, 6'd10});
    chk("chord_meta",   voice_meta,  {3'd3, 3'd2, 3'd1});
    beats(2);
    chk("chord_b2_active", voice_active, 3'b101);
    chk("chord_b2_done",   note_done, 1'b0);
    beats(2);
    chk("chord_b4_active", voice_active, 3'b100);
    chk("chord_b4_done",   note_done, 1'b0);
    beats(2);
    chk("chord_b6_active", voice_active, 3'b000);
    chk("chord_b6_done",   note_done, 1'b1);
    cyc();
    chk("chord_done_1cyc", note_done, 1'b0);

    // Steal: remaining {5,2,2}; slot 1 is the lowest-index minimum.
    nn(6'd1, 6'd5, 3'd0);
    nn(6'd2, 6'd2, 3'd0);
    nn(6'd3, 6'd2, 3'd0);
    chk("steal_pre_ovf", overflow, 1'b0);
    nn(6'd30, 6'd4, 3'd7);
    chk("steal_ovf",    overflow, 1'b1);
    chk("steal_active", voice_active, 3'b111);
    chk("steal_notes",  voice_notes, {6'd3, 6'd30, 6'd1});
    chk("steal_meta1",  voice_meta[5:3], 3'd7);
    cyc();
    chk("steal_ovf_1cyc", overflow, 1'b0);
    beats(2);
    chk("steal_b2_active", voice_active, 3'b011);
    beats(2);
    chk("steal_b4_active", voice_active, 3'b001);
    beats(1);
    chk("steal_b5_active", voice_active, 3'b000);
    chk("steal_b5_done",   note_done, 1'b1);
    cyc();

    // Expiry and load together, lone slot 0 at remaining 1: load goes to idle slot 1.
    nn(6'd7, 6'd1, 3'd0);
    beat = 1'b1;
    nn(6'd40, 6'd2, 3'd0);
    beat = 1'b0;
    chk("sim1_active", voice_active, 3'b010);
    chk("sim1_note1",  voice_notes[11:6], 6'd40);
    chk("sim1_done",   note_done, 1'b0);
    chk("sim1_ovf",    overflow, 1'b0);
    beats(2);
    chk("sim1_b2_active", voice_active, 3'b000);
    chk("sim1_b2_done",   note_done, 1'b1);
    cyc();

    // Expiry and load together with all slots busy: slot 0 (rem 1) is reloaded, no overflow.
    nn(6'd8,  6'd1, 3'd0);
    nn(6'd9,  6'd3, 3'd0);
    nn(6'd11, 6'd3, 3'd0);
    beat = 1'b1;
    nn(6'd40, 6'd2, 3'd4);
    beat = 1'b0;
    chk("sim3_active", voice_active, 3'b111);
    chk("sim3_note0",  voice_notes[5:0], 6'd40);
    chk("sim3_meta0",  voice_meta[2:0], 3'd4);
    chk("sim3_ovf",    overflow, 1'b0);
    chk("sim3_done",   note_done, 1'b0);
    beats(1);
    chk("sim3_b1_active", voice_active, 3'b111);
    beats(1);
    chk("sim3_b2_active", voice_active, 3'b000);
    chk("sim3_b2_done",   note_done, 1'b1);
    cyc();

    // Pause freezes the countdown; zero duration is ignored.
    nn(6'd50, 6'd3, 3'd0);
    play = 1'b0;
    beats(5);
    chk("pause_active", voice_active, 3'b001);
    nn(6'd60, 6'd0, 3'd6);
    chk("zero_active", voice_active, 3'b001);
    chk("zero_notes",  voice_notes, {6'd11, 6'd9, 6'd50});
    chk("zero_ovf",    overflow, 1'b0);
    play = 1'b1;
    beats(2);
    chk("resume_b2_active", voice_active, 3'b001);
    beats(1);
    chk("resume_b3_active", voice_active, 3'b000);
    chk("resume_b3_done",   note_done, 1'b1);
    cyc();

    // Reset mid-chord, with a note offered during the reset cycle.
    nn(6'd21, 6'd5, 3'd1);
    nn(6'd22, 6'd5, 3'd2);
    chk("rmc_pre_active", voice_active, 3'b011);
    reset = 1'b0;
    beat  = 1'b1;
    nn(6'd23, 6'd5, 3'd3);
    beat  = 1'b0;
    reset = 1'b1;
    chk("rmc_active", voice_active, 3'b000);
    chk("rmc_notes",  voice_notes, 18'd0);
    chk("rmc_meta",   voice_meta, 9'd0);
    chk("rmc_done",   note_done, 1'b0);
    chk("rmc_ovf",    overflow, 1'b0);
    cyc();
    chk("rmc_done_after", note_done, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
